cp_copyblock_scheduler: RTL and testbench

Sequences COPYBLOCK commands from the Control Processor to the Memory Control Unit (MCU).
- Buffers CP commands in a small FIFO so the CP does not stall on back-to-back COPYBLOCKs.
- Issues one command at a time to the MCU with a request/grant handshake, then waits for completion.
- Tracks outstanding commands per TAG value so CP code can poll for tag completion before DELIVER_COMMAND START_MAIN_THREAD.

---
 rtl/cp_copyblock_scheduler.sv | 132 +++++++++++++
 tb/tb_cp_copyblock_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cp_copyblock_scheduler.sv
// cp_copyblock_scheduler: queues CP COPYBLOCK commands and issues them one at a time to the MCU with per-tag completion tracking.
// Define CP_COPYBLOCK_WATCHDOG_EN to enable the WAIT-state watchdog that drives oTimeout.
module cp_copyblock_scheduler #(
    parameter int CMD_W          = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_BIT        = 63,
    parameter int BLKLEN_LSB     = 48,
    parameter int BLKLEN_W       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [CMD_W-1:0] iCopyBlockCommand,
    input  logic             iCopyBlockValid,
    output logic             oCopyBlockReady,
    output logic [CMD_W-1:0] oMcuCommand,
    output logic             oMcuRequest,
    input  logic             iMcuGrant,
    input  logic             iMcuDone,
    output logic [1:0]       oTagIdle,
    output logic             oBusy,
    output logic             oTimeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CMD_W-1:0] mcu_cmd_q, mcu_cmd_d;
    logic [CW-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [CMD_W-1:0] head;
    logic             empty, full, push, pop, retire, retire_tag, wd_expire;

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign push  = iCopyBlockValid & ~full;

    always_comb begin
        state_d    = state_q;
        mcu_cmd_d  = mcu_cmd_q;
        pop        = 1'b0;
        retire     = 1'b0;
        retire_tag = mcu_cmd_q[TAG_BIT];
        case (state_q)
            IDLE: if (!empty) begin
                // Zero-length copies retire straight from the queue without touching the MCU.
                if (head[BLKLEN_LSB +: BLKLEN_W] == '0) begin
                    pop        = 1'b1;
                    retire     = 1'b1;
                    retire_tag = head[TAG_BIT];
                end else begin
                    mcu_cmd_d = head;
                    state_d   = ISSUE;
                end
            end
            ISSUE: if (iMcuGrant) begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (iMcuDone || wd_expire) begin
                retire  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt0_d   = cnt0_q + CW'(push & ~iCopyBlockCommand[TAG_BIT]) - CW'(retire & ~retire_tag);
        cnt1_d   = cnt1_q + CW'(push &  iCopyBlockCommand[TAG_BIT]) - CW'(retire &  retire_tag);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mcu_cmd_q <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mcu_cmd_q <= mcu_cmd_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= iCopyBlockCommand;
    end

`ifdef CP_COPYBLOCK_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;

    // Counter sits at zero outside WAIT, so it starts fresh on every entry.
    always_comb begin
        wd_d      = (state_q == WAIT) ? wd_q + 1'b1 : '0;
        wd_expire = (state_q == WAIT) && !iMcuDone && (wd_q == TW'(TIMEOUT_CYCLES - 1));
        timeout_d = timeout_q | wd_expire;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign oTimeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign oTimeout  = 1'b0;
`endif

    assign oCopyBlockReady = ~full;
    assign oMcuCommand     = mcu_cmd_q;
    assign oMcuRequest     = state_q == ISSUE;
    assign oTagIdle        = {cnt1_q == '0, cnt0_q == '0};
    assign oBusy           = ~empty | (state_q != IDLE);
endmodule

// File: tb/tb_cp_copyblock_scheduler.sv
// tb_cp_copyblock_scheduler: directed-vector bench for cp_copyblock_scheduler with hand-computed expectations.
// The watchdog scenario runs only when CP_COPYBLOCK_WATCHDOG_EN is defined.
module tb_cp_copyblock_scheduler;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [63:0] iCopyBlockCommand = '0;
    logic        iCopyBlockValid = 1'b0;
    logic        oCopyBlockReady;
    logic [63:0] oMcuCommand;
    logic        oMcuRequest;
    logic        iMcuGrant = 1'b0;
    logic        iMcuDone = 1'b0;
    logic [1:0]  oTagIdle;
    logic        oBusy;
    logic        oTimeout;
    int          errors = 0;
    int          checks = 0;

    cp_copyblock_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .iCopyBlockCommand(iCopyBlockCommand), .iCopyBlockValid(iCopyBlockValid),
        .oCopyBlockReady(oCopyBlockReady), .oMcuCommand(oMcuCommand),
        .oMcuRequest(oMcuRequest), .iMcuGrant(iMcuGrant), .iMcuDone(iMcuDone),
        .oTagIdle(oTagIdle), .oBusy(oBusy), .oTimeout(oTimeout)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic tag, input logic [7:0] len, input logic [47:0] pay);
        return {tag, 7'h0, len, pay};
    endfunction

    task automatic push(input logic [63:0] cmd);
        iCopyBlockValid   = 1'b1;
        iCopyBlockCommand = cmd;
        tick();
        iCopyBlockValid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 64'(oMcuRequest), 64'd0);
        check({tag, "_cmd"}, oMcuCommand, 64'd0);
        check({tag, "_busy"}, 64'(oBusy), 64'd0);
        check({tag, "_tagidle"}, 64'(oTagIdle), 64'd3);
        check({tag, "_timeout"}, 64'(oTimeout), 64'd0);
        check({tag, "_ready"}, 64'(oCopyBlockReady), 64'd1);
    endtask

    task automatic serve(input string tag, input logic [63:0] cmd);
        for (int n = 0; n < 20 && !oMcuRequest; n++) tick();
        check({tag, "_req"}, 64'(oMcuRequest), 64'd1);
        check({tag, "_cmd"}, oMcuCommand, cmd);
        iMcuGrant = 1'b1;
        tick();
        iMcuGrant = 1'b0;
        check({tag, "_req_drop"}, 64'(oMcuRequest), 64'd0);
        iMcuDone = 1'b1;
        tick();
        iMcuDone = 1'b0;
    endtask

    initial begin
        logic [63:0] a, z, c, d;
        logic [63:0] b [5];
        tick();
        tick();
        Reset = 1'b0;
        check_reset_outputs("rst");

        // Single command, grant 3 cycles after request, done 5 cycles after grant.
        a = mk(1'b0, 8'd8, 48'h1234_5678_9abc);
        push(a);
        check("s1_req_early", 64'(oMcuRequest), 64'd0);
        check("s1_tagidle_q", 64'(oTagIdle), 64'd2);
        tick();
        check("s1_req", 64'(oMcuRequest), 64'd1);
        check("s1_cmd", oMcuCommand, a);
        tick();
        tick();
        check("s1_req_hold", 64'(oMcuRequest), 64'd1);
        iMcuGrant = 1'b1;
        tick();
        iMcuGrant = 1'b0;
        check("s1_req_off", 64'(oMcuRequest), 64'd0);
        check("s1_tagidle_wait", 64'(oTagIdle), 64'd2);
        for (int i = 0; i < 4; i++) tick();
        check("s1_busy_wait", 64'(oBusy), 64'd1);
        iMcuDone = 1'b1;
        tick();
        iMcuDone = 1'b0;
        check("s1_tagidle_done", 64'(oTagIdle), 64'd3);
        check("s1_busy_done", 64'(oBusy), 64'd0);

        // Five back-to-back pushes with the MCU withholding grant.
        for (int i = 0; i < 5; i++) b[i] = mk(i == 4, 8'd1, 48'(i + 16));
        for (int i = 0; i < 4; i++) push(b[i]);
        check("s2_ready_full", 64'(oCopyBlockReady), 64'd0);
        check("s2_cmd_b0", oMcuCommand, b[0]);
        iCopyBlockValid   = 1'b1;
        iCopyBlockCommand = b[4];
        tick();
        check("s2_ready_still", 64'(oCopyBlockReady), 64'd0);
        iMcuGrant = 1'b1;
        tick();
        iMcuGrant = 1'b0;
        check("s2_ready_back", 64'(oCopyBlockReady), 64'd1);
        tick();
        iCopyBlockValid = 1'b0;
        check("s2_ready_refull", 64'(oCopyBlockReady), 64'd0);
        check("s2_tagidle", 64'(oTagIdle), 64'd0);
        iMcuDone = 1'b1;
        tick();
        iMcuDone = 1'b0;
        check("s2_req_gap", 64'(oMcuRequest), 64'd0);
        tick();
        check("s2_req_b1", 64'(oMcuRequest), 64'd1);
        for (int i = 1; i < 5; i++) serve($sformatf("s2_b%0d", i), b[i]);
        check("s2_tagidle_end", 64'(oTagIdle), 64'd3);
        check("s2_busy_end", 64'(oBusy), 64'd0);

        // Zero-length tag0 retires without a request; tag1 follows normally.
        z = mk(1'b0, 8'd0, 48'hdead);
        c = mk(1'b1, 8'd4, 48'hbeef);
        d = mk(1'b1, 8'd2, 48'hcafe);
        push(z);
        check("s3_tagidle_z", 64'(oTagIdle), 64'd2);
        push(c);
        check("s3_req_z", 64'(oMcuRequest), 64'd0);
        check("s3_tagidle_pop", 64'(oTagIdle), 64'd1);
        tick();
        check("s3_req_c", 64'(oMcuRequest), 64'd1);
        check("s3_cmd_c", oMcuCommand, c);
        iMcuGrant = 1'b1;
        tick();
        iMcuGrant = 1'b0;
        tick();
        // Push a tag1 command on the same edge the tag1 done arrives.
        iMcuDone          = 1'b1;
        iCopyBlockValid   = 1'b1;
        iCopyBlockCommand = d;
        tick();
        iMcuDone        = 1'b0;
        iCopyBlockValid = 1'b0;
        check("s4_tagidle_same", 64'(oTagIdle), 64'd1);
        check("s4_busy", 64'(oBusy), 64'd1);
        serve("s4_d", d);
        check("s4_tagidle_end", 64'(oTagIdle), 64'd3);

        // Reset while in ISSUE with three commands queued, then a stray done.
        push(mk(1'b0, 8'd5, 48'h1));
        push(mk(1'b1, 8'd6, 48'h2));
        push(mk(1'b0, 8'd7, 48'h3));
        check("s5_req_pre", 64'(oMcuRequest), 64'd1);
        check("s5_tagidle_pre", 64'(oTagIdle), 64'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_reset_outputs("s5_rst");
        iMcuDone = 1'b1;
        tick();
        iMcuDone = 1'b0;
        tick();
        tick();
        check_reset_outputs("s5_post");

`ifdef CP_COPYBLOCK_WATCHDOG_EN
        // Granted tag1 command never completes; the watchdog retires it.
        a = mk(1'b1, 8'd3, 48'h77);
        c = mk(1'b0, 8'd3, 48'h88);
        push(a);
        push(c);
        check("s6_cmd_a", oMcuCommand, a);
        iMcuGrant = 1'b1;
        tick();
        iMcuGrant = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("s6_timeout_pre", 64'(oTimeout), 64'd0);
        check("s6_tagidle_pre", 64'(oTagIdle), 64'd0);
        tick();
        check("s6_timeout", 64'(oTimeout), 64'd1);
        check("s6_tagidle", 64'(oTagIdle), 64'd2);
        tick();
        check("s6_req_next", 64'(oMcuRequest), 64'd1);
        serve("s6_c", c);
        check("s6_timeout_sticky", 64'(oTimeout), 64'd1);
        check("s6_tagidle_end", 64'(oTagIdle), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
